fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the MIPS image pipeline, directly upstream of register_file.
//  Owns the PC and issues one request at a time to instruction memory.
//  Captures the returned word into the IF/ID register, whose instruction output drives
//  register_file's instruction input.
//  Handles ID back-pressure (stall), EX redirects (branch/jump flush) and variable memory latency.
// PARAMETERS
//  PC_RESET  32'h0000_0000  PC value loaded on reset
//  NOP       32'h0000_0000  word driven on instruction when IF/ID holds a bubble
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  imem_addr    out  32  fetch address, word aligned
//  imem_req     out  1   fetch request, one-cycle pulse per access
//  imem_rdata   in   32  returned instruction word
//  imem_rvalid  in   1   imem_rdata valid; arrives >=1 cycle after imem_req
//  stall_id     in   1   ID cannot accept a new instruction this cycle
//  redirect     in   1   EX branch/jump taken; flush and refetch
//  redirect_pc  in   32  new fetch target; bits[1:0] ignored (forced 0)
//  instruction  out  32  IF/ID instruction -> register_file
//  pc_plus4     out  32  IF/ID PC+4 of held instruction
//  if_valid     out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pc=PC_RESET, state=IDLE, imem_req=0, imem_addr=PC_RESET.
//   - instruction=NOP, pc_plus4=0, if_valid=0, skid empty.
//  Registered outputs: imem_req=(state==REQ); imem_addr=pc.
//  FSM states IDLE, REQ, WAIT, HOLD, DROP:
//   - IDLE: -> REQ on first clk after reset release.
//   - REQ: request issued this cycle -> WAIT. Exactly one access is outstanding.
//   - WAIT, imem_rvalid, IF/ID free (!if_valid | !stall_id): load instruction, pc_plus4=pc+4,
//     if_valid=1; pc+=4; -> REQ.
//   - WAIT, imem_rvalid, IF/ID busy: word to skid register -> HOLD.
//   - HOLD, stall_id=0: skid -> IF/ID (if_valid=1), pc+=4 -> REQ. Min fetch period = 2 cycles.
//   - DROP: discard next imem_rvalid word -> REQ.
//  IF/ID bubble: stall_id=0, no new word loaded -> if_valid=0, instruction=NOP.
//  IF/ID hold: stall_id=1 & if_valid=1 -> instruction/pc_plus4 unchanged.
//  Redirect (highest priority, beats stall and rvalid):
//   - pc=redirect_pc&~3; if_valid=0, instruction=NOP, skid cleared.
//   - From IDLE, HOLD, or WAIT with rvalid in the same cycle: word discarded -> REQ.
//   - From REQ, or WAIT without rvalid: access in flight -> DROP.
//   - In DROP: pc updated, stay DROP.
//  PC arithmetic: 32-bit unsigned, 32'hFFFF_FFFC + 4 wraps to 0; pc_plus4 wraps the same way.
//  rvalid outside WAIT/DROP is ignored (protocol error, no state change).
//  Reset mid-access: all state cleared at once. The outstanding response after reset is
//   ignored because state is IDLE/REQ.
// TESTING
//  1 Reset, 1-cycle memory returning 0x22310000 @0, 0x22310111 @4 -> imem_addr 0,4,8;
//    instruction/if_valid=1 in that order; pc_plus4 4 then 8.
//  2 stall_id=1 for 3 cycles while a word returns -> HOLD entered; IF/ID unchanged;
//    imem_req stays 0; word delivered the cycle after stall release.
//  3 redirect=1, redirect_pc=0x103 while in WAIT; rvalid 2 cycles later -> word dropped;
//    next imem_addr=0x100; if_valid=0 meanwhile.
//  4 redirect and imem_rvalid same cycle in WAIT -> word discarded, next req to redirect_pc.
//  5 redirect together with stall_id=1 and if_valid=1 -> if_valid=0, instruction=NOP.
//  6 PC_RESET=0xFFFF_FFFC -> first pc_plus4=0, second imem_addr=0.
//    Then rst_n=0 mid-WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one instruction-memory access in
// flight at a time, and fills the IF/ID register that feeds register_file.
// It handles ID back-pressure with a one-word skid register, EX redirects by
// flushing and refetching, and any memory latency of one cycle or more.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        stall_id,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        if_valid
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_skid, w_skid_nxt;
  logic [31:0] r_instr, r_pc4;
  logic        r_vld;

  logic        w_free;     // IF/ID can take a word at this edge
  logic        w_load;     // IF/ID takes w_load_data at this edge
  logic [31:0] w_load_data;
  logic [31:0] w_pc4;
  logic [31:0] w_rpc;

  assign w_free    = !r_vld || !stall_id;
  assign w_pc4     = r_pc + 32'd4;          // wraps modulo 2^32
  assign w_rpc     = redirect_pc & ~32'h3;

  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = r_pc;
  assign instruction = r_instr;
  assign pc_plus4    = r_pc4;
  assign if_valid    = r_vld;

  // State, PC and skid register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= PC_RESET;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  // Next-state, PC and IF/ID load decision; redirect overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_skid_nxt  = r_skid;
    w_load      = 1'b0;
    w_load_data = r_skid;
    if (redirect) begin
      w_pc_nxt   = w_rpc;
      w_skid_nxt = '0;
      case (r_state)
        S_REQ:   w_state_nxt = S_DROP;
        S_WAIT:  w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
        // A response landing in the same cycle retires the in-flight access,
        // so waiting for another one would never end.
        S_DROP:  w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
        default: w_state_nxt = S_REQ;
      endcase
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_REQ;
        S_REQ:  w_state_nxt = S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            if (w_free) begin
              w_load      = 1'b1;
              w_load_data = imem_rdata;
              w_pc_nxt    = w_pc4;
              w_state_nxt = S_REQ;
            end else begin
              w_skid_nxt  = imem_rdata;
              w_state_nxt = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall_id) begin
            w_load      = 1'b1;
            w_load_data = r_skid;
            w_skid_nxt  = '0;
            w_pc_nxt    = w_pc4;
            w_state_nxt = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) w_state_nxt = S_REQ;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // IF/ID register: flush on redirect, load new word, bubble when consumed, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= NOP;
      r_pc4   <= '0;
      r_vld   <= 1'b0;
    end else if (redirect) begin
      r_instr <= NOP;
      r_vld   <= 1'b0;
    end else if (w_load) begin
      r_instr <= w_load_data;
      r_pc4   <= w_pc4;
      r_vld   <= 1'b1;
    end else if (!stall_id) begin
      r_instr <= NOP;
      r_vld   <= 1'b0;
    end
  end

endmodule
